parity_deser_chk: RTL and testbench
===================================

Name: parity_deser_chk

Overview:
- Serial-to-parallel receive stage sitting directly upstream of the team's 32-bit odd/even parity check logic.
- Collects a serial frame of DATA_W data bits plus one trailing parity bit, assembles the data word, and checks parity with the same sel convention as the parity check stage.
- Presents the word with a one-cycle valid strobe, an error flag, and a saturating error counter.
- Aborts partial frames that stall beyond a timeout.

Parameters:
DATA_W, 32, data bits per frame (≥2); parity bit follows the last data bit
TO_CYC, 16, consecutive idle (din_vld=0) cycles mid-frame that abort the frame (≥1)
CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
din  input  1  serial data, MSB first, sampled only when din_vld=1
din_vld  input  1  din carries a valid bit this cycle
sel  input  1  parity mode, latched on the first data bit of a frame; 1=odd check, 0=even check
cnt_clr  input  1  synchronous clear of err_cnt
dout  output  DATA_W  last assembled data word
dout_vld  output  1  one-cycle strobe, dout/par_err valid
par_err  output  1  parity mismatch for the current dout, valid with dout_vld
to_err  output  1  one-cycle strobe, frame aborted by timeout
busy  output  1  frame in progress (state != IDLE)
err_cnt  output  CNT_W  count of parity errors plus timeouts, saturating

Behaviour:
- Reset (async, rst=1): state IDLE, dout=0, dout_vld=0, par_err=0, to_err=0, err_cnt=0, bit counter=0, idle counter=0, latched sel=0.
- FSM states:
  - IDLE: din_vld=1 → shift din into the data register, latch sel, bit_cnt=1, go to DATA. If DATA_W==1 is disallowed, go to PAR.
  - DATA: each din_vld=1 shifts din in from the LSB side (first bit ends as MSB) and increments bit_cnt. When the DATA_W-th bit is accepted, go to PAR.
  - PAR: din_vld=1 takes din as the received parity bit p, then:
    - expected = sel_l ? ^data : ~^data
    - dout ← data, par_err ← (p != expected), dout_vld=1 for the next cycle
    - return to IDLE
- Output timing:
  - Latency: dout_vld asserts in the cycle after the parity bit is sampled, for exactly one cycle.
  - dout/par_err hold their values until the next dout_vld.
- Back-to-back frames: a new frame's first bit may arrive in the cycle dout_vld is high; it is accepted with no bubble.
- Timeout:
  - In DATA or PAR, the idle counter increments on each din_vld=0 cycle and clears on din_vld=1.
  - When it reaches TO_CYC: discard the partial frame, pulse to_err for one cycle, return to IDLE. dout is unchanged and dout_vld is not asserted.
  - The idle counter is not active in IDLE.
- err_cnt:
  - Increments by 1 on each dout_vld with par_err=1 and on each to_err.
  - Saturates at 2^CNT_W−1.
  - cnt_clr=1 forces 0 next cycle and wins over a simultaneous increment.
- sel changes mid-frame are ignored; only the latched value is used.
- Reset mid-frame: the frame is lost and no strobes are generated.

Test Plan:
- Odd mode: sel=1, serialize 0x0000_0001 then p=1 (expected ^data=1) → dout=0x0000_0001, dout_vld one cycle after p, par_err=0, err_cnt=0.
- Even mode error: sel=0, data 0xFFFF_FFFF, p=0 (expected ~^data=1) → par_err=1, err_cnt=1. Repeat with p=1 → par_err=0, err_cnt stays 1.
- Gapped input: 0xA5A5_5A5A with random din_vld gaps ≤TO_CYC−1 → correct dout, no to_err. Toggling sel mid-frame does not change the result.
- Timeout: send 10 bits, then hold din_vld=0 for 16 cycles → to_err pulses exactly on the 16th idle cycle, busy drops, dout keeps its previous value, err_cnt+1. The next full frame decodes correctly.
- Back-to-back and saturation: CNT_W=2, five consecutive bad-parity frames with no gaps → five dout_vld strobes, err_cnt 1,2,3,3,3. Then cnt_clr asserted together with a sixth error → err_cnt=0.
- Async reset: assert rst at bit 20 of a frame → all outputs 0 immediately, no strobes. After release, a full frame decodes correctly.

Source files
------------

// File: rtl/parity_deser_chk.sv
// parity_deser_chk: serial-to-parallel receive stage with parity check.
// Collects DATA_W data bits (MSB first) plus one trailing parity bit,
// presents the assembled word with a one-cycle valid strobe and parity
// error flag, aborts stalled partial frames, and keeps a saturating count
// of parity errors and timeouts.
//
// Handshake: a serial bit is transferred on every rising clk edge where
// din_vld=1 (there is no back-pressure; the receiver is always ready).
// dout_vld and to_err are single-cycle strobes; dout/par_err hold their
// values until the next dout_vld.
module parity_deser_chk #(
   parameter int DATA_W = 32,
   parameter int TO_CYC = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_vld,
   input  logic              sel,
   input  logic              cnt_clr,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld,
   output logic              par_err,
   output logic              to_err,
   output logic              busy,
   output logic [CNT_W-1:0]  err_cnt
);

   localparam int BC_W = $clog2(DATA_W + 1);
   localparam int IC_W = $clog2(TO_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAR  = 2'd2
   } state_t;

   state_t              r_state;
   logic [DATA_W-1:0]   r_shift;
   logic [DATA_W-1:0]   r_dout;
   logic [BC_W-1:0]     r_bit_cnt;
   logic [IC_W-1:0]     r_idle_cnt;
   logic                r_sel;
   logic                r_dout_vld;
   logic                r_par_err;
   logic                r_to_err;
   logic [CNT_W-1:0]    r_err_cnt;

   logic                w_exp_par;
   logic                w_par_evt;
   logic                w_to_evt;

   // Parity the sender should have appended, using the mode latched at frame start.
   assign w_exp_par = r_sel ? (^r_shift) : (~^r_shift);

   // Events that bump the error counter: a mismatching parity bit being accepted,
   // or the last allowed idle cycle of a stalled frame elapsing.
   always_comb begin
      w_par_evt = 1'b0;
      w_to_evt  = 1'b0;
      if ((r_state == S_PAR) && din_vld && (din != w_exp_par)) begin
         w_par_evt = 1'b1;
      end
      if ((r_state != S_IDLE) && !din_vld && (r_idle_cnt == IC_W'(TO_CYC - 1))) begin
         w_to_evt = 1'b1;
      end
   end

   // Frame FSM: bit collection, parity capture, timeout abort, registered strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_dout     <= '0;
         r_bit_cnt  <= '0;
         r_idle_cnt <= '0;
         r_sel      <= 1'b0;
         r_dout_vld <= 1'b0;
         r_par_err  <= 1'b0;
         r_to_err   <= 1'b0;
      end else begin
         r_dout_vld <= 1'b0;
         r_to_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_idle_cnt <= '0;
               if (din_vld) begin
                  r_shift   <= {r_shift[DATA_W-2:0], din};
                  r_sel     <= sel;
                  r_bit_cnt <= BC_W'(1);
                  r_state   <= S_DATA;
               end
            end
            S_DATA, S_PAR: begin
               if (din_vld) begin
                  r_idle_cnt <= '0;
                  if (r_state == S_DATA) begin
                     r_shift <= {r_shift[DATA_W-2:0], din};
                     if (r_bit_cnt == BC_W'(DATA_W - 1)) begin
                        r_bit_cnt <= '0;
                        r_state   <= S_PAR;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                     end
                  end else begin
                     r_dout     <= r_shift;
                     r_par_err  <= (din != w_exp_par);
                     r_dout_vld <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end else if (w_to_evt) begin
                  // Stalled too long: drop the partial word, keep dout as is.
                  r_idle_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_to_err   <= 1'b1;
                  r_state    <= S_IDLE;
               end else begin
                  r_idle_cnt <= r_idle_cnt + IC_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Saturating error counter; a clear request beats a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (cnt_clr) begin
         r_err_cnt <= '0;
      end else if ((w_par_evt || w_to_evt) && (r_err_cnt != {CNT_W{1'b1}})) begin
         r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
   end

   assign dout     = r_dout;
   assign dout_vld = r_dout_vld;
   assign par_err  = r_par_err;
   assign to_err   = r_to_err;
   assign busy     = (r_state != S_IDLE);
   assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_parity_deser_chk.sv
// tb_parity_deser_chk: self-checking bench for parity_deser_chk.
// Table-driven frames, hand-written timeout / saturation / reset sequences,
// and randomized gapped frames checked against a word-level reference model.
module tb_parity_deser_chk;

   localparam int DATA_W = 32;
   localparam int TO_CYC = 16;
   localparam int CNT_W  = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk;
   logic              rst;
   logic              din;
   logic              din_vld;
   logic              sel;
   logic              cnt_clr;
   logic [DATA_W-1:0] dout;
   logic              dout_vld;
   logic              par_err;
   logic              to_err;
   logic              busy;
   logic [CNT_W-1:0]  err_cnt;

   int n_checks;
   int n_errors;

   // Reference model state: last delivered word and error count.
   logic [DATA_W-1:0] exp_dout;
   int                exp_cnt;
   bit                clr_on_par;

   typedef struct {
      logic [DATA_W-1:0] data;
      bit                s;
      bit                p;
      bit                exp_err;
   } vec_t;

   vec_t vecs[7];

   parity_deser_chk #(
      .DATA_W (DATA_W),
      .TO_CYC (TO_CYC),
      .CNT_W  (CNT_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .din_vld  (din_vld),
      .sel      (sel),
      .cnt_clr  (cnt_clr),
      .dout     (dout),
      .dout_vld (dout_vld),
      .par_err  (par_err),
      .to_err   (to_err),
      .busy     (busy),
      .err_cnt  (err_cnt)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Word-level parity rule: sel=1 expects the XOR of the data bits,
   // sel=0 expects its complement.
   function automatic bit model_err(input logic [DATA_W-1:0] data, input bit s, input bit p);
      bit odd_ones;
      odd_ones = ($countones(data) % 2) == 1;
      return p != (s ? odd_ones : !odd_ones);
   endfunction

   function automatic int sat_inc(input int c);
      return (c >= CNT_MAX) ? CNT_MAX : c + 1;
   endfunction

   task automatic chk_mid(input string name);
      chk({name, "_mid"}, {61'd0, dout_vld, to_err, busy}, 64'b001);
   endtask

   // Sends one full frame; max_gap>0 inserts random idle gaps between bits,
   // tog makes sel wander after the first bit. Checks the result strobe.
   task automatic send_frame(input logic [DATA_W-1:0] data, input bit s, input bit p,
                             input int max_gap, input bit tog, input bit exp_err,
                             input string name);
      bit b;
      int gap;
      for (int i = 0; i <= DATA_W; i++) begin
         if (i > 0 && max_gap > 0) begin
            gap = $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
               din_vld = 1'b0;
               din     = 1'($urandom_range(0, 1));
               if (tog) sel = 1'($urandom_range(0, 1));
               step();
               chk_mid(name);
            end
         end
         b       = (i < DATA_W) ? data[DATA_W-1-i] : p;
         din     = b;
         din_vld = 1'b1;
         sel     = (i == 0 || !tog) ? s : 1'($urandom_range(0, 1));
         cnt_clr = (i == DATA_W) ? clr_on_par : 1'b0;
         step();
         cnt_clr = 1'b0;
         if (i < DATA_W) chk_mid(name);
      end
      din_vld  = 1'b0;
      exp_dout = data;
      if (clr_on_par) exp_cnt = 0;
      else if (exp_err) exp_cnt = sat_inc(exp_cnt);
      chk({name, "_vld"},  {62'd0, dout_vld, busy}, 64'b10);
      chk({name, "_dout"}, 64'(dout), 64'(data));
      chk({name, "_perr"}, 64'(par_err), 64'(exp_err));
      chk({name, "_cnt"},  64'(err_cnt), 64'(exp_cnt));
   endtask

   // Sends only the first n data bits of a frame, with no gaps.
   task automatic send_bits(input logic [DATA_W-1:0] data, input bit s, input int n);
      for (int i = 0; i < n; i++) begin
         din     = data[DATA_W-1-i];
         din_vld = 1'b1;
         sel     = s;
         step();
         chk_mid("part");
      end
      din_vld = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk(name, {dout, dout_vld, par_err, to_err, busy, err_cnt}, '0);
   endtask

   initial begin
      logic [DATA_W-1:0] rd;
      bit rs, rp, e;
      n_checks   = 0;
      n_errors   = 0;
      exp_dout   = '0;
      exp_cnt    = 0;
      clr_on_par = 1'b0;

      vecs[0] = '{32'h0000_0001, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
      vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0};
      vecs[3] = '{32'h0000_0000, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{32'h0000_0000, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{32'h8000_0003, 1'b1, 1'b1, 1'b0};
      vecs[6] = '{32'h1234_5678, 1'b0, 1'b0, 1'b0};

      // Reset
      rst = 1'b1; din = 1'b0; din_vld = 1'b0; sel = 1'b0; cnt_clr = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk_all_zero("post_reset");

      // Table frames, back to back
      for (int k = 0; k < 7; k++) begin
         send_frame(vecs[k].data, vecs[k].s, vecs[k].p, 0, 1'b0, vecs[k].exp_err, $sformatf("tbl%0d", k));
      end
      step();
      chk("hold_vld", 64'(dout_vld), 64'd0);
      chk("hold_dout", 64'(dout), 64'(exp_dout));
      chk("hold_perr", 64'(par_err), 64'(vecs[6].exp_err));

      // Clear counter
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0; exp_cnt = 0;
      chk("clr", 64'(err_cnt), 64'd0);

      // Gapped frame with sel toggling mid-frame
      for (int k = 0; k < 2; k++) begin
         rs = k[0];
         send_frame(32'hA5A5_5A5A, rs, 1'b0, TO_CYC - 1, 1'b1,
                    model_err(32'hA5A5_5A5A, rs, 1'b0), "gap");
      end

      // Timeout after 10 bits
      step();
      send_bits(32'hDEAD_BEEF, 1'b1, 10);
      for (int k = 1; k <= TO_CYC; k++) begin
         din_vld = 1'b0;
         step();
         if (k < TO_CYC) begin
            chk("to_wait", {62'd0, to_err, busy}, 64'b01);
         end else begin
            exp_cnt = sat_inc(exp_cnt);
            chk("to_pulse", {61'd0, to_err, busy, dout_vld}, 64'b100);
            chk("to_dout", 64'(dout), 64'(exp_dout));
            chk("to_cnt", 64'(err_cnt), 64'(exp_cnt));
         end
      end
      step();
      chk("to_once", 64'(to_err), 64'd0);
      send_frame(32'hC0FF_EE01, 1'b1, 1'b1, 0, 1'b0, model_err(32'hC0FF_EE01, 1'b1, 1'b1), "after_to");

      // Saturation: five bad frames back to back, then clear with a sixth error
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0; exp_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         rd = $urandom();
         rs = 1'($urandom_range(0, 1));
         rp = !model_err(rd, rs, 1'b0) ? 1'b1 : 1'b0;
         send_frame(rd, rs, rp, 0, 1'b0, 1'b1, $sformatf("sat%0d", k));
         chk($sformatf("sat_cnt%0d", k), 64'(err_cnt), 64'((k < 3) ? k + 1 : 3));
      end
      clr_on_par = 1'b1;
      rd = $urandom();
      rp = !model_err(rd, 1'b0, 1'b0) ? 1'b1 : 1'b0;
      send_frame(rd, 1'b0, rp, 0, 1'b0, 1'b1, "sat_clr");
      clr_on_par = 1'b0;

      // Asynchronous reset in the middle of a frame
      send_frame(32'h0F0F_00FF, 1'b1, 1'b1, 0, 1'b0, model_err(32'h0F0F_00FF, 1'b1, 1'b1), "pre_rst");
      send_bits(32'h1357_9BDF, 1'b1, 20);
      #3;
      rst = 1'b1;
      #1;
      chk_all_zero("arst_now");
      step();
      chk_all_zero("arst_hold");
      rst = 1'b0;
      exp_dout = '0;
      exp_cnt  = 0;
      repeat (3) begin
         step();
         chk_all_zero("arst_quiet");
      end
      send_frame(32'h2468_ACE0, 1'b0, 1'b1, 0, 1'b0, model_err(32'h2468_ACE0, 1'b0, 1'b1), "post_arst");

      // Randomized frames against the model
      for (int k = 0; k < 24; k++) begin
         rd = $urandom();
         rs = 1'($urandom_range(0, 1));
         rp = 1'($urandom_range(0, 1));
         e  = model_err(rd, rs, rp);
         if ($urandom_range(0, 3) == 0) step();
         send_frame(rd, rs, rp, ($urandom_range(0, 1) == 1) ? TO_CYC - 1 : 0, 1'b1, e,
                    $sformatf("rnd%0d", k));
      end
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
